// File: rtl/axi1_wr_arbiter_if.sv
// AXI write address/data channel bundle for DDR port 1 (no B channel on this port).
// The arbiter drives it through the master modport; the DDR controller side uses slave.
interface axi1_wr_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned LEN_W  = 8
);
  logic [ADDR_W-1:0] awaddr_1;
  logic [LEN_W-1:0]  awlen_1;
  logic              awvalid_1;
  logic              awready_1;
  logic [DATA_W-1:0] wdata_1;
  logic              wlast_1;
  logic              wvalid_1;
  logic              wready_1;

  modport master (
    output awaddr_1, awlen_1, awvalid_1,
    input  awready_1,
    output wdata_1, wlast_1, wvalid_1,
    input  wready_1
  );

  modport slave (
    input  awaddr_1, awlen_1, awvalid_1,
    output awready_1,
    input  wdata_1, wlast_1, wvalid_1,
    output wready_1
  );
endinterface

// File: rtl/axi1_wr_arbiter.sv
// Round-robin arbiter sharing DDR AXI write port 1 between two burst writers.
// Owns AW sequencing and wlast generation; clients supply only the data stream.
module axi1_wr_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_0,
  input  logic [ADDR_W-1:0] addr_0,
  input  logic [LEN_W-1:0]  len_0,
  input  logic [DATA_W-1:0] wdata_c0,
  input  logic              wvalid_c0,
  output logic              wready_c0,
  output logic              gnt_0,
  output logic              done_0,
  input  logic              req_1,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [LEN_W-1:0]  len_1,
  input  logic [DATA_W-1:0] wdata_c1,
  input  logic              wvalid_c1,
  output logic              wready_c1,
  output logic              gnt_1,
  output logic              done_1,
  axi1_wr_arbiter_if.master axi,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_rr_ptr, w_rr_ptr_nxt;
  logic              r_owner, w_owner_nxt;
  logic [ADDR_W-1:0] r_awaddr, w_awaddr_nxt;
  logic [LEN_W-1:0]  r_awlen, w_awlen_nxt;
  logic [LEN_W-1:0]  r_beat_cnt, w_beat_cnt_nxt;
  logic              r_awvalid, w_awvalid_nxt;
  logic              r_gnt_0, w_gnt_0_nxt, r_gnt_1, w_gnt_1_nxt;
  logic              r_done_0, w_done_0_nxt, r_done_1, w_done_1_nxt;

  logic              w_in_data;
  logic              w_wvalid;
  logic              w_wlast;
  logic              w_beat;
  logic              w_winner;

  // W channel is a pure mux from the current owner while in DATA
  assign w_in_data     = (r_state == DATA);
  assign w_wvalid      = w_in_data & (r_owner ? wvalid_c1 : wvalid_c0);
  assign w_wlast       = w_wvalid & (r_beat_cnt == r_awlen);
  assign w_beat        = w_wvalid & axi.wready_1;
  assign w_winner      = (req_0 & req_1) ? r_rr_ptr : req_1;

  assign axi.wvalid_1  = w_wvalid;
  assign axi.wlast_1   = w_wlast;
  assign axi.wdata_1   = w_in_data ? (r_owner ? wdata_c1 : wdata_c0) : '0;
  assign wready_c0     = w_in_data & ~r_owner & axi.wready_1;
  assign wready_c1     = w_in_data &  r_owner & axi.wready_1;

  assign axi.awaddr_1  = r_awaddr;
  assign axi.awlen_1   = r_awlen;
  assign axi.awvalid_1 = r_awvalid;
  assign gnt_0         = r_gnt_0;
  assign gnt_1         = r_gnt_1;
  assign done_0        = r_done_0;
  assign done_1        = r_done_1;
  assign busy          = (r_state != IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_rr_ptr   <= 1'b0;
      r_owner    <= 1'b0;
      r_awaddr   <= '0;
      r_awlen    <= '0;
      r_beat_cnt <= '0;
      r_awvalid  <= 1'b0;
      r_gnt_0    <= 1'b0;
      r_gnt_1    <= 1'b0;
      r_done_0   <= 1'b0;
      r_done_1   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_owner    <= w_owner_nxt;
      r_awaddr   <= w_awaddr_nxt;
      r_awlen    <= w_awlen_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
      r_awvalid  <= w_awvalid_nxt;
      r_gnt_0    <= w_gnt_0_nxt;
      r_gnt_1    <= w_gnt_1_nxt;
      r_done_0   <= w_done_0_nxt;
      r_done_1   <= w_done_1_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_owner_nxt    = r_owner;
    w_awaddr_nxt   = r_awaddr;
    w_awlen_nxt    = r_awlen;
    w_beat_cnt_nxt = r_beat_cnt;
    w_awvalid_nxt  = r_awvalid;
    w_gnt_0_nxt    = 1'b0;
    w_gnt_1_nxt    = 1'b0;
    w_done_0_nxt   = 1'b0;
    w_done_1_nxt   = 1'b0;

    case (r_state)
      IDLE: begin
        if (req_0 | req_1) begin
          w_owner_nxt   = w_winner;
          w_awaddr_nxt  = w_winner ? addr_1 : addr_0;
          w_awlen_nxt   = w_winner ? len_1 : len_0;
          w_awvalid_nxt = 1'b1;
          w_gnt_0_nxt   = ~w_winner;
          w_gnt_1_nxt   = w_winner;
          w_state_nxt   = ADDR;
        end
      end
      ADDR: begin
        if (r_awvalid & axi.awready_1) begin
          w_awvalid_nxt  = 1'b0;
          w_beat_cnt_nxt = '0;
          w_state_nxt    = DATA;
        end
      end
      DATA: begin
        // Last beat returns to IDLE without incrementing, so a full-length burst never wraps
        if (w_beat) begin
          if (w_wlast) begin
            w_done_0_nxt = ~r_owner;
            w_done_1_nxt = r_owner;
            w_rr_ptr_nxt = ~r_owner;
            w_state_nxt  = IDLE;
          end else begin
            w_beat_cnt_nxt = r_beat_cnt + LEN_W'(1);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule
